// File: rtl/snake_turn_ctrl.sv
// snake_turn_ctrl: debounces the cw/ccw turn buttons, queues turns and emits the periodic step pulse.
// Build option SNAKE_TURN_QUEUE_EN selects a 2-entry turn FIFO; otherwise a single overwrite slot is used.
module snake_turn_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         STEP_PERIOD     = 1000,
  parameter logic [1:0] DIR_RESET       = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_cw,
  input  logic       btn_ccw,
  input  logic       run,
  output logic [1:0] dir,
  output logic       step,
  output logic       turn_pending
);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_PERIOD - 1);

  // bit 0 is the clockwise button, bit 1 the counter-clockwise button
  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {btn_ccw, btn_cw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_q, sync1_d;
      logic            sync2_q, sync2_d;
      logic            level_q, level_d;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            rise;

      // level flips only after DEBOUNCE_CYCLES consecutive mismatching synced samples
      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise    = 1'b0;
        if (sync2_q != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
            rise    = sync2_q;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          level_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign press[gi] = rise;
    end
  endgenerate

  logic             enq, enq_cw;
  logic             pop;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             step_q, step_d;
  logic [1:0]       dir_q, dir_d;
  logic             pend_q, pend_d;
  logic             head_valid, head_cw;

  // a simultaneous press of both buttons cancels out
  assign enq    = press[0] ^ press[1];
  assign enq_cw = press[0];

  always_comb begin
    tmr_d  = tmr_q;
    step_d = 1'b0;
    pop    = 1'b0;
    if (run) begin
      if (tmr_q == TMR_LAST) begin
        tmr_d  = '0;
        step_d = 1'b1;
        pop    = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end
  end

`ifdef SNAKE_TURN_QUEUE_EN
  // slot 0 holds the oldest turn; valid entries are always packed from slot 0
  logic [1:0] qv_q, qv_d;
  logic [1:0] qt_q, qt_d;

  assign head_valid = qv_q[0];
  assign head_cw    = qt_q[0];

  always_comb begin
    qv_d = qv_q;
    qt_d = qt_q;
    if (pop) begin
      qv_d = {1'b0, qv_q[1]};
      qt_d = {1'b0, qt_q[1]};
    end
    if (enq) begin
      if (!qv_d[0]) begin
        qv_d[0] = 1'b1;
        qt_d[0] = enq_cw;
      end else if (!qv_d[1]) begin
        qv_d[1] = 1'b1;
        qt_d[1] = enq_cw;
      end
    end
    pend_d = |qv_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qv_q <= '0;
      qt_q <= '0;
    end else begin
      qv_q <= qv_d;
      qt_q <= qt_d;
    end
  end
`else
  logic slot_v_q, slot_v_d;
  logic slot_cw_q, slot_cw_d;

  assign head_valid = slot_v_q;
  assign head_cw    = slot_cw_q;

  // the newest press wins, including one landing on the same edge as a pop
  always_comb begin
    slot_v_d  = slot_v_q;
    slot_cw_d = slot_cw_q;
    if (pop) begin
      slot_v_d = 1'b0;
    end
    if (enq) begin
      slot_v_d  = 1'b1;
      slot_cw_d = enq_cw;
    end
    pend_d = slot_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q  <= 1'b0;
      slot_cw_q <= 1'b0;
    end else begin
      slot_v_q  <= slot_v_d;
      slot_cw_q <= slot_cw_d;
    end
  end
`endif

  always_comb begin
    dir_d = dir_q;
    if (pop && head_valid) begin
      dir_d = head_cw ? (dir_q + 2'd1) : (dir_q - 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= DIR_RESET;
      pend_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      pend_q <= pend_d;
    end
  end

  assign dir          = dir_q;
  assign step         = step_q;
  assign turn_pending = pend_q;
endmodule

// File: tb/tb_snake_turn_ctrl.sv
// Testbench for snake_turn_ctrl: directed scenarios with fixed expectations plus a randomized run
// compared every cycle against a queue-based behavioural model.
module tb_snake_turn_ctrl;
  localparam int DB = 4;
  localparam int SP = 10;
`ifdef SNAKE_TURN_QUEUE_EN
  localparam int QDEPTH = 2;
`else
  localparam int QDEPTH = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_cw;
  logic       btn_ccw;
  logic       run;
  logic [1:0] dir;
  logic       step;
  logic       turn_pending;

  int checks;
  int errors;

  snake_turn_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_PERIOD    (SP),
    .DIR_RESET      (2'b01)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_cw      (btn_cw),
    .btn_ccw     (btn_ccw),
    .run         (run),
    .dir         (dir),
    .step        (step),
    .turn_pending(turn_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a press is accepted after DB consecutive synced samples
  // (input seen two edges earlier) disagree with the accepted level; turns live in a queue.
  logic [1:0] dir_m;
  bit         step_m, pend_m;
  bit         cw_seen1, cw_seen2, ccw_seen1, ccw_seen2;
  bit         lvl_cw, lvl_ccw;
  int         mis_cw, mis_ccw, tcnt_m;
  bit         mq[$];
  bit         s_cw, s_ccw, p_cw, p_ccw, t_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_m = 2'b01; step_m = 0; pend_m = 0;
      cw_seen1 = 0; cw_seen2 = 0; ccw_seen1 = 0; ccw_seen2 = 0;
      lvl_cw = 0; lvl_ccw = 0; mis_cw = 0; mis_ccw = 0; tcnt_m = 0;
      mq.delete();
    end else begin
      s_cw = cw_seen2;   cw_seen2 = cw_seen1;   cw_seen1 = btn_cw;
      s_ccw = ccw_seen2; ccw_seen2 = ccw_seen1; ccw_seen1 = btn_ccw;
      p_cw = 0;
      if (s_cw != lvl_cw) begin
        mis_cw++;
        if (mis_cw == DB) begin lvl_cw = s_cw; p_cw = s_cw; mis_cw = 0; end
      end else mis_cw = 0;
      p_ccw = 0;
      if (s_ccw != lvl_ccw) begin
        mis_ccw++;
        if (mis_ccw == DB) begin lvl_ccw = s_ccw; p_ccw = s_ccw; mis_ccw = 0; end
      end else mis_ccw = 0;
      step_m = 0;
      if (run) begin
        if (tcnt_m == SP - 1) begin
          tcnt_m = 0;
          step_m = 1;
          if (mq.size() > 0) begin
            t_m = mq.pop_front();
            dir_m = t_m ? dir_m + 2'd1 : dir_m - 2'd1;
          end
        end else tcnt_m++;
      end
      if (p_cw ^ p_ccw) begin
        if (QDEPTH == 1) mq.delete();
        if (mq.size() < QDEPTH) mq.push_back(p_cw);
      end
      pend_m = (mq.size() != 0);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; btn_cw = 1'b0; btn_ccw = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
  endtask

  task automatic wait_step(output bit seen, output int n);
    seen = 0;
    n = 0;
    while (!seen && n < 4 * SP) begin
      @(negedge clk);
      n++;
      if (step === 1'b1) seen = 1;
    end
  endtask

  task automatic hold_btns(input bit cw, input bit ccw, input int n);
    btn_cw = cw;
    btn_ccw = ccw;
    repeat (n) @(negedge clk);
    btn_cw = 1'b0;
    btn_ccw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_cw = 1'b0; btn_ccw = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; run = 1'b1; btn_cw = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (turn_pending !== 1'b1) begin
      errors++; $display("FAIL reset_pre_pending got %b need 1", turn_pending);
    end
    repeat (2) @(negedge clk);
    btn_cw = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (step !== 1'b1 || dir !== 2'b10) begin
      errors++; $display("FAIL reset_pre_step got step=%b dir=%b need step=1 dir=10", step, dir);
    end
    btn_ccw = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dir !== 2'b01 || step !== 1'b0 || turn_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got dir=%b step=%b pend=%b need 01/0/0", dir, step, turn_pending);
    end
    $display("reset: asserted mid-count, dir=%b step=%b pend=%b", dir, step, turn_pending);
    btn_ccw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (step !== (k % SP == 0)) begin
        errors++; $display("FAIL reset_step_timing cycle %0d got step=%b need %b", k, step, (k % SP == 0));
      end
      if (k % SP == 0) begin
        checks++;
        if (dir !== 2'b01) begin
          errors++; $display("FAIL reset_step_dir cycle %0d got %b need 01", k, dir);
        end
        $display("reset: step at cycle %0d dir=%b", k, dir);
      end
    end
  endtask

  task automatic test_bounce();
    bit seen;
    int n;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) btn_cw = ~btn_cw;
      @(negedge clk);
    end
    btn_cw = 1'b0;
    for (int s = 0; s < 5; s++) begin
      wait_step(seen, n);
      checks++;
      if (!seen || dir !== 2'b01 || turn_pending !== 1'b0) begin
        errors++;
        $display("FAIL bounce_step %0d got seen=%b dir=%b pend=%b need 1/01/0", s, seen, dir, turn_pending);
      end
      $display("bounce: step %0d dir=%b", s, dir);
    end
    hold_btns(1'b1, 1'b0, 8);
    checks++;
    if (turn_pending !== 1'b1) begin
      errors++; $display("FAIL bounce_hold_pending got %b need 1", turn_pending);
    end
    wait_step(seen, n);
    checks++;
    if (!seen || n != 2 || dir !== 2'b10 || turn_pending !== 1'b0) begin
      errors++;
      $display("FAIL bounce_hold_step got seen=%b n=%0d dir=%b pend=%b need 1/2/10/0", seen, n, dir, turn_pending);
    end
    $display("bounce: held press applied dir=%b", dir);
  endtask

  task automatic test_wrap();
    bit seen;
    int n;
    logic [1:0] exp_dir [4];
    exp_dir[0] = 2'b10; exp_dir[1] = 2'b11; exp_dir[2] = 2'b00; exp_dir[3] = 2'b11;
    do_reset();
    wait_step(seen, n);
    for (int i = 0; i < 4; i++) begin
      hold_btns(i < 3, i == 3, 8);
      checks++;
      if (turn_pending !== 1'b1) begin
        errors++; $display("FAIL wrap_pending %0d got %b need 1", i, turn_pending);
      end
      wait_step(seen, n);
      checks++;
      if (!seen || dir !== exp_dir[i]) begin
        errors++; $display("FAIL wrap_dir %0d got seen=%b dir=%b need %b", i, seen, dir, exp_dir[i]);
      end
      $display("wrap: turn %0d dir=%b", i, dir);
      wait_step(seen, n);
    end
  endtask

  task automatic test_simultaneous();
    bit seen;
    int n;
    do_reset();
    wait_step(seen, n);
    btn_cw = 1'b1;
    btn_ccw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (turn_pending !== 1'b0) begin
        errors++; $display("FAIL simul_pending cycle %0d got %b need 0", i, turn_pending);
      end
    end
    btn_cw = 1'b0;
    btn_ccw = 1'b0;
    wait_step(seen, n);
    checks++;
    if (!seen || dir !== 2'b01 || turn_pending !== 1'b0) begin
      errors++; $display("FAIL simul_step got seen=%b dir=%b pend=%b need 1/01/0", seen, dir, turn_pending);
    end
    $display("simultaneous: dir=%b after step", dir);
    wait_step(seen, n);
  endtask

  task automatic test_pause();
    bit seen;
    int n;
    do_reset();
    wait_step(seen, n);
    repeat (5) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (step !== 1'b0) begin
        errors++; $display("FAIL pause_step cycle %0d got %b need 0", i, step);
      end
    end
    run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (step !== (k == 5)) begin
        errors++; $display("FAIL pause_resume cycle %0d got %b need %b", k, step, (k == 5));
      end
    end
    $display("pause: resumed, step after 5 cycles");
  endtask

  task automatic test_queue();
    bit seen;
    int n;
    logic [1:0] exp1, exp2;
    logic       exp_pend1;
`ifdef SNAKE_TURN_QUEUE_EN
    exp1 = 2'b10; exp2 = 2'b01; exp_pend1 = 1'b1;
`else
    exp1 = 2'b00; exp2 = 2'b00; exp_pend1 = 1'b0;
`endif
    do_reset();
    wait_step(seen, n);
    btn_cw = 1'b1;
    repeat (3) @(negedge clk);
    btn_ccw = 1'b1;
    repeat (3) @(negedge clk);
    btn_cw = 1'b0;
    repeat (3) @(negedge clk);
    btn_ccw = 1'b0;
    checks++;
    if (turn_pending !== 1'b1) begin
      errors++; $display("FAIL queue_pending got %b need 1", turn_pending);
    end
    @(negedge clk);
    checks++;
    if (step !== 1'b1 || dir !== exp1 || turn_pending !== exp_pend1) begin
      errors++;
      $display("FAIL queue_step1 got step=%b dir=%b pend=%b need 1/%b/%b", step, dir, turn_pending, exp1, exp_pend1);
    end
    $display("queue: step1 dir=%b", dir);
    wait_step(seen, n);
    checks++;
    if (!seen || dir !== exp2 || turn_pending !== 1'b0) begin
      errors++; $display("FAIL queue_step2 got seen=%b dir=%b pend=%b need 1/%b/0", seen, dir, turn_pending, exp2);
    end
    $display("queue: step2 dir=%b", dir);
  endtask

  task automatic test_random();
    int cw_left, ccw_left;
    cw_left = 0;
    ccw_left = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if (dir !== dir_m || step !== step_m || turn_pending !== pend_m) begin
        errors++;
        $display("FAIL random cycle %0d got dir=%b step=%b pend=%b need dir=%b step=%b pend=%b",
                 c, dir, step, turn_pending, dir_m, step_m, pend_m);
      end
      if (step_m) $display("random: cycle %0d step dir=%b pend=%b", c, dir_m, pend_m);
      if (cw_left == 0) begin
        btn_cw = 1'($urandom_range(0, 1)); cw_left = $urandom_range(1, 9);
      end else cw_left--;
      if (ccw_left == 0) begin
        btn_ccw = 1'($urandom_range(0, 1)); ccw_left = $urandom_range(1, 9);
      end else ccw_left--;
      if ($urandom_range(0, 15) == 0) begin
        btn_ccw = btn_cw; ccw_left = cw_left;
      end
      if ($urandom_range(0, 39) == 0) run = ~run;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    btn_cw = 1'b0;
    btn_ccw = 1'b0;
    run = 1'b0;
    test_reset();
    test_bounce();
    test_wrap();
    test_simultaneous();
    test_pause();
    test_queue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
